mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-004 The block SHALL have port fn, input, mul_fn_t (3 bits): RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-005 The block SHALL have ports a and b, input, word_t (32 bits): operands, same sources as the ALU a/b; sampled with start.
REQ-006 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse; r valid this cycle.
REQ-008 The block SHALL have port r, output, word_t: result, registered, feeds the writeback mux beside the ALU result.

Function
REQ-009 The block SHALL implement states IDLE, RUN and FINISH.
REQ-010 In IDLE, start=1 at an edge SHALL latch fn, a and b, take operand magnitudes per signedness, set step counter to 0 and enter RUN.
REQ-011 RUN SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle, for exactly 32 cycles, counter 0..31.
REQ-012 After step 31 RUN SHALL enter FINISH; FINISH SHALL apply sign correction, register r, and return to IDLE.
REQ-013 done SHALL be 1 for exactly the one cycle following the FINISH edge, i.e. 33 edges after the start edge; busy SHALL be 1 from the edge after start until FINISH completes, and 0 during the done cycle.
REQ-014 start SHALL be accepted in the done cycle (back-to-back operation); start while busy SHALL be ignored with no effect on state, operands or r.
REQ-015 MUL SHALL return low 32 bits of the product; MULH, MULHSU and MULHU SHALL return high 32 bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-016 DIV/REM SHALL truncate toward zero; the REM sign SHALL equal the sign of a.
REQ-017 If b=0, the block SHALL skip RUN and finish at the next edge: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a; done 1 edge after start.
REQ-018 DIV of 0x80000000 by 0xFFFFFFFF SHALL skip RUN, giving 0x80000000; REM of the same operands SHALL give 0; done 1 edge after start.
REQ-019 r SHALL hold its value between done pulses; changes to a, b or fn after start SHALL NOT affect the result.

Reset
REQ-020 reset=1 SHALL immediately force state IDLE, busy=0, done=0, r=0 and counter=0, regardless of state.
REQ-021 Reset mid-RUN SHALL abandon the operation without asserting done; the first start after release SHALL run normally.

Structure
REQ-022 mul_fn_t (funct3 encoding) and constant MUL_DIV_STEPS=32 SHALL live in opcodes_pkg; word_t SHALL be used from types_pkg.
REQ-023 The block SHALL be a single module sharing one 64-bit accumulator/remainder register and one 33-bit adder between multiply and divide; no sub-module.

Verification
REQ-024 The bench SHALL cover MUL with a=7, b=0xFFFFFFFD -> r=0xFFFFFFEB, done exactly 33 edges after start, busy high throughout.
REQ-025 The bench SHALL cover MULH with a=b=0x80000000 -> r=0x40000000; MULHU with a=b=0xFFFFFFFF -> r=0xFFFFFFFE; MULHSU with a=b=0xFFFFFFFF -> r=0xFFFFFFFF.
REQ-026 The bench SHALL cover DIV with a=0xFFFFFFF9, b=2 -> r=0xFFFFFFFD; REM with the same operands -> r=0xFFFFFFFF; DIVU 100/7 -> r=14; REMU 100/7 -> r=2.
REQ-027 The bench SHALL cover DIVU 5/0 -> r=0xFFFFFFFF and REM 5/0 -> r=5, plus DIV 0x80000000/0xFFFFFFFF -> r=0x80000000; each with done 1 edge after start.
REQ-028 The bench SHALL cover start pulsed at RUN step 10 with different operands -> first result unchanged; then back-to-back start in the done cycle -> second result 33 edges later.
REQ-029 The bench SHALL cover reset asserted at RUN step 10 -> busy=0, done=0, r=0 immediately with no done pulse; then MUL 3×4 after release -> r=12.

Source files
------------

// File: rtl/opcodes_pkg.sv
// RV32M funct3 encodings and multiply/divide iteration count.
package opcodes_pkg;

  typedef enum logic [2:0] {
    FN_MUL    = 3'b000,
    FN_MULH   = 3'b001,
    FN_MULHSU = 3'b010,
    FN_MULHU  = 3'b011,
    FN_DIV    = 3'b100,
    FN_DIVU   = 3'b101,
    FN_REM    = 3'b110,
    FN_REMU   = 3'b111
  } mul_fn_t;

  localparam int unsigned MUL_DIV_STEPS = 32;

endpackage

// File: rtl/types_pkg.sv
// Shared datapath types used across the core.
package types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// magnitudes, sharing one 64-bit accumulator and one 33-bit adder, sign fixed at the end.
module mul_div_unit
  import types_pkg::*;
  import opcodes_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  input  mul_fn_t fn,
  input  word_t   a,
  input  word_t   b,
  output logic    busy,
  output logic    done,
  output word_t   r
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [1:0]  state_r;
  logic [4:0]  cnt_r;
  mul_fn_t     fn_r;
  logic [63:0] acc_r;   // {hi, lo}: product, or {remainder, quotient}
  word_t       dsr_r;   // multiplicand or divisor magnitude
  logic        neg_r;

  logic        a_signed_s, b_signed_s, special_s, neg_s;
  word_t       a_mag_s, b_mag_s;
  logic [32:0] add_a_s, add_b_s;
  logic        add_cin_s;
  logic [33:0] sum_s;
  logic [63:0] acc_next_s, prod_s;
  word_t       quo_s, rem_s, res_s;

  // Operand signedness, magnitudes and early-exit detection at start
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (fn)
      FN_MULH:        begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      FN_MULHSU:      begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
      FN_DIV, FN_REM: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      default:        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
    endcase
    a_mag_s   = (a_signed_s && a[31]) ? (32'd0 - a) : a;
    b_mag_s   = (b_signed_s && b[31]) ? (32'd0 - b) : b;
    special_s = fn[2] && ((b == 32'd0) ||
                (a_signed_s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    if (fn == FN_REM) begin
      neg_s = a_signed_s && a[31];
    end else begin
      neg_s = (a_signed_s && a[31]) ^ (b_signed_s && b[31]);
    end
  end

  // Shared adder: hi + M for multiply, shifted remainder - M for divide
  always_comb begin
    if (fn_r[2]) begin
      add_a_s    = acc_r[63:31];
      add_b_s    = ~{1'b0, dsr_r};
      add_cin_s  = 1'b1;
    end else begin
      add_a_s    = {1'b0, acc_r[63:32]};
      add_b_s    = {1'b0, dsr_r};
      add_cin_s  = 1'b0;
    end
    sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {33'd0, add_cin_s};
    if (fn_r[2]) begin
      // carry out means the trial subtraction did not borrow
      acc_next_s = sum_s[33] ? {sum_s[31:0], acc_r[30:0], 1'b1} : {acc_r[62:0], 1'b0};
    end else begin
      acc_next_s = acc_r[0] ? {sum_s[32:0], acc_r[31:1]} : {1'b0, acc_r[63:1]};
    end
  end

  // Sign correction and result selection for the FINISH state
  always_comb begin
    prod_s = neg_r ? (64'd0 - acc_r) : acc_r;
    quo_s  = neg_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
    rem_s  = neg_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
    case (fn_r)
      FN_MUL:                       res_s = prod_s[31:0];
      FN_MULH, FN_MULHSU, FN_MULHU: res_s = prod_s[63:32];
      FN_DIV, FN_DIVU:              res_s = quo_s;
      FN_REM, FN_REMU:              res_s = rem_s;
      default:                      res_s = 32'd0;
    endcase
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      fn_r    <= FN_MUL;
      acc_r   <= 64'd0;
      dsr_r   <= 32'd0;
      neg_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      r       <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            fn_r  <= fn;
            cnt_r <= 5'd0;
            dsr_r <= b_mag_s;
            busy  <= 1'b1;
            if (special_s) begin
              // preload so FINISH yields the architected divide-by-zero/overflow values
              state_r <= ST_FINISH;
              neg_r   <= 1'b0;
              acc_r   <= (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'd0, 32'h8000_0000};
            end else begin
              state_r <= ST_RUN;
              neg_r   <= neg_s;
              acc_r   <= {32'd0, a_mag_s};
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'(MUL_DIV_STEPS - 1)) begin
            state_r <= ST_FINISH;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FINISH: begin
          r       <= res_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
